div_seq: RTL and testbench



---
 rtl/div_pkg.sv | 27 ++
 rtl/div_step.sv | 31 +++
 rtl/div_seq.sv | 124 ++++++++++++
 tb/tb_div_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : div_pkg
// Brief   : Shared types, default widths and helpers for the sequential
//           restoring divider.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
package div_pkg;

  // Default widths: a 4-bit product divided by a 2-bit factor
  localparam int DEF_DW = 4;
  localparam int DEF_VW = 2;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The iteration counter holds DW-1, so $clog2(DW) bits are sufficient
  function automatic int cnt_width(input int dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : div_step
// Brief   : One restoring-division compare/subtract cell. Shifts the next
//           dividend bit into the partial remainder and subtracts the divisor
//           when it fits.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module div_step #(
  parameter int VW = 2
) (
  input  logic [VW:0]   r_i,    // current partial remainder
  input  logic          bit_i,  // next dividend bit, MSB first
  input  logic [VW-1:0] d_i,    // divisor
  output logic [VW:0]   r_o,    // next partial remainder
  output logic          q_o     // quotient bit produced by this step
);

  logic [VW:0] w_shift;
  logic [VW:0] w_dext;

  // The remainder is always below D, so dropping its top bit on the shift is lossless
  always_comb begin
    w_shift = {r_i[VW-1:0], bit_i};
    w_dext  = {1'b0, d_i};
    q_o     = (w_shift >= w_dext);
    r_o     = q_o ? (w_shift - w_dext) : w_shift;
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : div_seq
// Brief   : Sequential unsigned restoring divider with valid/ready handshake.
//           One quotient bit per cycle, DW cycles per division; D=0 yields
//           an all-ones quotient, zero remainder and div_by_zero set.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module div_seq
  import div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = cnt_width(DW);

  state_t        state_q, state_d;
  logic [DW-1:0] nq_q, nq_d;      // dividend shifts out the top, quotient in the bottom
  logic [VW:0]   r_q, r_d;        // partial remainder, one bit wider than D
  logic [VW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   w_r_next;
  logic          w_qbit;

  div_step #(
    .VW (VW)
  ) u_step (
    .r_i   (r_q),
    .bit_i (nq_q[DW-1]),
    .d_i   (d_q),
    .r_o   (w_r_next),
    .q_o   (w_qbit)
  );

  // Handshake and result outputs depend only on registered state
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    quotient    = nq_q;
    remainder   = r_q[VW-1:0];
    div_by_zero = dbz_q;
  end

  // Next-state and datapath update for accept, iterate and result hand-off
  always_comb begin
    state_d = state_q;
    nq_d    = nq_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d = divisor;
          r_d = '0;
          if (divisor != '0) begin
            nq_d    = dividend;
            dbz_d   = 1'b0;
            cnt_d   = CW'(DW - 1);
            state_d = CALC;
          end else begin
            // Divide by zero skips iteration and reports a saturated quotient
            nq_d    = '1;
            dbz_d   = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        nq_d = {nq_q[DW-2:0], w_qbit};
        r_d  = w_r_next;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      nq_q    <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nq_q    <= nq_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule : div_seq
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_div_seq
// Brief   : Self-checking bench for div_seq with default widths (4/2).
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_div_seq;

  localparam int DW = 4;
  localparam int VW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int total = 0;
  int bad   = 0;

  div_seq #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference results from plain integer arithmetic
  function automatic int ref_q(input int n, input int d);
    return (d == 0) ? (1 << DW) - 1 : n / d;
  endfunction

  function automatic int ref_r(input int n, input int d);
    return (d == 0) ? 0 : n % d;
  endfunction

  task automatic check_result(input string tag, input int n, input int d);
    check({tag, "_q"},   32'(quotient),    32'(ref_q(n, d)));
    check({tag, "_r"},   32'(remainder),   32'(ref_r(n, d)));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(d == 0));
  endtask

  // Full transaction: accept, wait with noisy operands, hold, hand off
  task automatic run_op(input string tag, input int n, input int d,
                        input int pre_gap, input int hold, input bit verbose);
    int lat;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < pre_gap; i++) tick();
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = DW'(n);
    divisor  = VW'(d);
    tick();  // accepting edge E0
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom);
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'((d == 0) ? 0 : DW));
    check_result(tag, n, d);
    if (verbose) check({tag, "_busy"}, 32'(in_ready), 32'd0);
    if (d != 0) begin
      check({tag, "_inv"}, 32'(int'(quotient) * d + int'(remainder)), 32'(n));
      check({tag, "_rlt"}, 32'(int'(remainder) < d), 32'd1);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
      tick();
      check({tag, "_hold_v"},   32'(out_valid), 32'd1);
      check({tag, "_hold_rdy"}, 32'(in_ready),  32'd0);
      check_result({tag, "_hold"}, n, d);
    end
    // Result taken, possibly alongside new operands that must be ignored
    out_ready = 1'b1;
    in_valid  = 1'($urandom);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_taken_v"},   32'(out_valid), 32'd0);
    check({tag, "_taken_rdy"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rdy", 32'(in_ready),    32'd1);
    check("rst_v",   32'(out_valid),   32'd0);
    check("rst_q",   32'(quotient),    32'd0);
    check("rst_r",   32'(remainder),   32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases
    run_op("d13_3", 13, 3, 0, 0, 1'b1);
    run_op("d15_1", 15, 1, 1, 0, 1'b1);
    run_op("d2_3",  2,  3, 0, 0, 1'b1);
    run_op("d9_0",  9,  0, 0, 0, 1'b1);

    // Back-pressure: ten cycles in DONE with noisy operands
    run_op("bp", 11, 2, 0, 10, 1'b1);

    // Reset during the second CALC cycle
    in_valid = 1'b1;
    dividend = 4'd13;
    divisor  = 2'd3;
    tick();  // E0
    in_valid = 1'b0;
    tick();  // E1: now in the second CALC cycle
    #2 rst_n = 1'b0;
    #1;
    check("arst_rdy", 32'(in_ready),    32'd1);
    check("arst_v",   32'(out_valid),   32'd0);
    check("arst_q",   32'(quotient),    32'd0);
    check("arst_r",   32'(remainder),   32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    tick();
    check("arst_hold_v", 32'(out_valid), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    run_op("d6_2", 6, 2, 0, 0, 1'b1);

    // Every operand pair with random gaps and back-pressure
    for (int n = 0; n < (1 << DW); n++) begin
      for (int d = 0; d < (1 << VW); d++) begin
        run_op("ex", n, d, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_div_seq
`default_nettype wire
